// File: rtl/cache_async_pkg.sv
// Shared constants for the asynchronous request bridges that feed the cache
// controller clock domain.
package cache_async_pkg;

  // Token width produced by the upstream click-based arbiter-merge.
  localparam int DATA_WIDTH_DEF  = 6;

  // Depth of the request-toggle synchronizer (legal range 2..3).
  localparam int SYNC_STAGES_DEF = 2;

  // Output FIFO depth in the controller domain.
  localparam int OUT_DEPTH       = 2;

  // Widths derived from the FIFO depth.
  localparam int PTR_WIDTH       = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CNT_WIDTH       = $clog2(OUT_DEPTH + 1);

  // Pointer increment with natural wrap for a power-of-two depth.
  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] ptr);
    return ptr + PTR_WIDTH'(1);
  endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit multi-flop synchronizer with asynchronous active-low reset to 0.
// The chain is kept intact and packed together by the attributes below so
// placement keeps the stages adjacent for metastability resolution.
module cdc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE", dont_touch = "true" *) logic [STAGES-1:0] sync_reg;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], d};
    end
  end

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/cache_req_sync_bridge.sv
// Bridge from the click-based arbiter-merge into the cache controller clock.
// A token is captured on the rising edge of i_drive together with a request
// toggle; the toggle is synchronized into clk, compared with the last seen
// toggle, and a pending token is moved into a 2-entry valid/ready FIFO.
// The move edge registers a one-cycle o_free pulse that releases upstream.
module cache_req_sync_bridge
  import cache_async_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_drive,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_free,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_ready
);

  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(OUT_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  // Capture side (clocked by the upstream drive edge).
  logic [DATA_WIDTH-1:0] cap_reg;
  logic                  req_tgl_reg;

  // Controller-domain state.
  logic                  req_tgl_sync;
  logic                  seen_tgl_reg;
  logic                  free_reg;
  logic [DATA_WIDTH-1:0] mem_reg [OUT_DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr_reg;
  logic [PTR_WIDTH-1:0]  rd_ptr_reg;
  logic [CNT_WIDTH-1:0]  count_reg;
  logic [CNT_WIDTH-1:0]  count_next;

  logic pending;
  logic push;
  logic pop;

  // Latch the token and flip the request toggle on each drive rise.
  always_ff @(posedge i_drive or negedge rstn) begin
    if (!rstn) begin
      cap_reg     <= '0;
      req_tgl_reg <= 1'b0;
    end else begin
      cap_reg     <= i_data;
      req_tgl_reg <= ~req_tgl_reg;
    end
  end

  cdc_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (req_tgl_reg),
    .q    (req_tgl_sync)
  );

  // A toggle differing from the last accepted one means cap_reg holds a new
  // token. cap_reg is stable here because upstream waits for o_free.
  assign pending = req_tgl_sync ^ seen_tgl_reg;
  assign push    = pending && (count_reg < CNT_FULL);
  assign pop     = o_valid && i_ready;

  // Acknowledge the accepted toggle and register the release pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seen_tgl_reg <= 1'b0;
      free_reg     <= 1'b0;
    end else begin
      if (push) begin
        seen_tgl_reg <= ~seen_tgl_reg;
      end
      free_reg <= push;
    end
  end

  // Per-entry FIFO storage, written only at the tail slot on a push.
  generate
    for (genvar gi = 0; gi < OUT_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          mem_reg[gi] <= '0;
        end else if (push && (wr_ptr_reg == PTR_WIDTH'(gi))) begin
          mem_reg[gi] <= cap_reg;
        end
      end
    end
  endgenerate

  // Occupancy update; a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CNT_ONE;
    end else if (pop && !push) begin
      count_next = count_reg - CNT_ONE;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      count_reg <= count_next;
    end
  end

  // Outputs are pure functions of registers only.
  assign o_free  = free_reg;
  assign o_valid = (count_reg != '0);
  assign o_data  = mem_reg[rd_ptr_reg];

endmodule

// File: tb/tb_cache_req_sync_bridge.sv
// Directed bench for cache_req_sync_bridge: a table of single-token vectors
// plus hand-written sequences for reset, backpressure, simultaneous push/pop,
// reset mid-flight and a randomized stream.
module tb_cache_req_sync_bridge;

  localparam int DW = 6;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          i_drive = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          i_ready = 1'b0;
  logic          o_free;
  logic          o_valid;
  logic [DW-1:0] o_data;

  cache_req_sync_bridge #(
    .DATA_WIDTH  (DW),
    .SYNC_STAGES (SS)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .i_drive (i_drive),
    .i_data  (i_data),
    .o_free  (o_free),
    .o_valid (o_valid),
    .o_data  (o_data),
    .i_ready (i_ready)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            passes = 0;
  int            free_cnt = 0;
  logic          prev_free = 1'b0;
  logic [DW-1:0] popped_q[$];
  logic [DW-1:0] exp_q[$];
  bit            stress_done = 1'b0;

  typedef struct {
    logic [DW-1:0] data;
    logic [DW-1:0] exp_data;
    int            max_lat;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor on the falling edge: count o_free pulses and log accepted tokens.
  always @(negedge clk) begin
    if (o_free) begin
      free_cnt++;
      check("free_not_consecutive", {31'd0, prev_free}, 32'd0);
    end
    prev_free = o_free;
    if (o_valid && i_ready) popped_q.push_back(o_data);
  end

  task automatic drive_token(input logic [DW-1:0] d);
    i_data  = d;
    #1 i_drive = 1'b1;
    #1 i_drive = 1'b0;
  endtask

  task automatic wait_free(input int budget, input string name);
    int  start;
    bit  seen;
    start = free_cnt;
    seen  = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      #1;
      if (free_cnt > start) seen = 1'b1;
    end
    check(name, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int q0;
    int f0;
    int lat;
    bit got;

    vecs[0] = '{6'h2A, 6'h2A, SS + 2};
    vecs[1] = '{6'h00, 6'h00, SS + 2};
    vecs[2] = '{6'h3F, 6'h3F, SS + 2};
    vecs[3] = '{6'h15, 6'h15, SS + 2};
    vecs[4] = '{6'h01, 6'h01, SS + 2};
    vecs[5] = '{6'h2A, 6'h2A, SS + 2};

    // Reset held low for 3 cycles while i_drive toggles.
    rstn = 1'b0;
    i_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #2;
      i_data  = 6'h3C;
      i_drive = ~i_drive;
      @(negedge clk); #1;
      check("rst_valid", {31'd0, o_valid}, 32'd0);
      check("rst_free",  {31'd0, o_free},  32'd0);
      check("rst_data",  {26'd0, o_data},  32'd0);
    end
    i_drive = 1'b0;
    @(posedge clk); #2;
    rstn = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    check("post_rst_free_cnt", free_cnt, 0);
    check("post_rst_valid", {31'd0, o_valid}, 32'd0);
    check("post_rst_no_token", popped_q.size(), 0);

    // Table-driven single tokens with i_ready held high.
    for (int v = 0; v < 6; v++) begin
      q0 = popped_q.size();
      f0 = free_cnt;
      @(posedge clk); #2;
      drive_token(vecs[v].data);
      lat = 0;
      got = 1'b0;
      for (int e = 1; e <= 12 && !got; e++) begin
        @(negedge clk); #1;
        if (o_valid) begin
          got = 1'b1;
          lat = e;
        end
      end
      repeat (4) @(negedge clk);
      #1;
      check("vec_valid_seen", {31'd0, got}, 32'd1);
      check("vec_latency_ok", {31'd0, (lat <= vecs[v].max_lat)}, 32'd1);
      check("vec_free_pulses", free_cnt - f0, 1);
      check("vec_pop_count", popped_q.size() - q0, 1);
      if (popped_q.size() > q0) check("vec_data", {26'd0, popped_q[q0]}, {26'd0, vecs[v].exp_data});
      $display("vec %0d: data=%02h latency=%0d edges", v, vecs[v].data, lat);
    end

    // Backpressure: three tokens into a 2-deep FIFO with i_ready low.
    @(posedge clk); #2;
    i_ready = 1'b0;
    q0 = popped_q.size();
    f0 = free_cnt;
    @(posedge clk); #2; drive_token(6'h01);
    wait_free(20, "bp_free1");
    @(posedge clk); #2; drive_token(6'h02);
    wait_free(20, "bp_free2");
    @(posedge clk); #2; drive_token(6'h03);
    repeat (10) @(negedge clk);
    #1;
    check("bp_third_pending", free_cnt - f0, 2);
    check("bp_full_valid", {31'd0, o_valid}, 32'd1);
    check("bp_full_head", {26'd0, o_data}, 32'h01);
    @(posedge clk); #2; i_ready = 1'b1;
    @(posedge clk); #2; i_ready = 1'b0;
    wait_free(20, "bp_free3");
    check("bp_head_after_pop", {26'd0, o_data}, 32'h02);
    @(posedge clk); #2; i_ready = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("bp_pop_count", popped_q.size() - q0, 3);
    if (popped_q.size() >= q0 + 3) begin
      check("bp_order0", {26'd0, popped_q[q0]},     32'h01);
      check("bp_order1", {26'd0, popped_q[q0 + 1]}, 32'h02);
      check("bp_order2", {26'd0, popped_q[q0 + 2]}, 32'h03);
    end
    $display("backpressure: %0d tokens popped in order", popped_q.size() - q0);

    // Simultaneous push and pop on the transfer edge with one entry buffered.
    @(posedge clk); #2;
    i_ready = 1'b0;
    q0 = popped_q.size();
    drive_token(6'h0A);
    wait_free(20, "pp_free_a");
    @(posedge clk); #2;
    drive_token(6'h0B);
    @(posedge clk);
    @(posedge clk); #2;
    i_ready = 1'b1;
    @(posedge clk); #2;
    i_ready = 1'b0;
    @(negedge clk); #1;
    check("pp_free_on_transfer", {31'd0, o_free}, 32'd1);
    check("pp_valid", {31'd0, o_valid}, 32'd1);
    check("pp_data_advanced", {26'd0, o_data}, 32'h0B);
    repeat (2) @(negedge clk);
    #1;
    check("pp_count_one_valid", {31'd0, o_valid}, 32'd1);
    @(posedge clk); #2; i_ready = 1'b1;
    @(posedge clk); #2; i_ready = 1'b0;
    @(negedge clk); #1;
    check("pp_empty_after_one_pop", {31'd0, o_valid}, 32'd0);
    check("pp_pop_count", popped_q.size() - q0, 2);
    if (popped_q.size() >= q0 + 2) begin
      check("pp_order0", {26'd0, popped_q[q0]},     32'h0A);
      check("pp_order1", {26'd0, popped_q[q0 + 1]}, 32'h0B);
    end
    $display("push/pop: head advanced to %02h", 6'h0B);

    // Reset asserted after the drive rise but before the transfer.
    @(posedge clk); #2;
    i_ready = 1'b1;
    q0 = popped_q.size();
    f0 = free_cnt;
    drive_token(6'h2C);
    @(posedge clk); #2;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rstn = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    check("mid_rst_no_free", free_cnt - f0, 0);
    check("mid_rst_valid", {31'd0, o_valid}, 32'd0);
    check("mid_rst_no_pop", popped_q.size() - q0, 0);
    @(posedge clk); #2;
    drive_token(6'h15);
    wait_free(20, "mid_rst_free_next");
    repeat (3) @(negedge clk);
    #1;
    check("mid_rst_next_count", popped_q.size() - q0, 1);
    if (popped_q.size() > q0) check("mid_rst_next_data", {26'd0, popped_q[q0]}, 32'h15);
    $display("reset mid-flight: token discarded, next token %02h delivered", 6'h15);

    // Random stress: 1000 tokens with random i_ready and drive spacing.
    q0 = popped_q.size();
    f0 = free_cnt;
    exp_q.delete();
    fork
      begin
        while (!stress_done) begin
          @(posedge clk); #2;
          i_ready = 1'($urandom_range(0, 1));
        end
      end
      begin
        for (int t = 0; t < 1000; t++) begin
          logic [DW-1:0] d;
          int dly;
          d   = DW'($urandom);
          dly = $urandom_range(1, 2);
          @(posedge clk);
          #(dly);
          exp_q.push_back(d);
          drive_token(d);
          wait_free(200, "stress_free");
          repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        stress_done = 1'b1;
      end
    join
    @(posedge clk); #2;
    i_ready = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("stress_free_count", free_cnt - f0, 1000);
    check("stress_pop_count", popped_q.size() - q0, exp_q.size());
    for (int k = 0; k < exp_q.size() && (q0 + k) < popped_q.size(); k++) begin
      check("stress_data", {26'd0, popped_q[q0 + k]}, {26'd0, exp_q[k]});
    end
    $display("stress: %0d tokens sent, %0d popped", exp_q.size(), popped_q.size() - q0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
